// File: rtl/aqp_esp_pkg.sv
// rtl/aqp_esp_pkg.sv - shared constants for the ESP UART TX FIFO write-side arbiter
package aqp_esp_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  localparam int ESP_SOF_BIT = 8;
  localparam int ESP_ENTRY_W = 9;
  localparam int GRANT_W     = 3;

  // FIFO entry: frame-start marker above the data byte
  function automatic logic [ESP_ENTRY_W-1:0] esp_entry(input logic sof, input logic [7:0] data);
    logic [ESP_ENTRY_W-1:0] e;
    e              = '0;
    e[7:0]         = data;
    e[ESP_SOF_BIT] = sof;
    return e;
  endfunction

endpackage

// File: rtl/aqp_rr_pick.sv
// rtl/aqp_rr_pick.sv - combinational round-robin picker, search starts just above ptr
module aqp_rr_pick
  import aqp_esp_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] ptr,
  output logic               found,
  output logic [GRANT_W-1:0] index
);

  // Each requester's distance from ptr+1 (mod NUM_REQ); the nearest set bit wins.
  always_comb begin
    int best_d;
    int d;
    found  = 1'b0;
    index  = '0;
    best_d = NUM_REQ;
    d      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + NUM_REQ - 1 - int'(ptr)) % NUM_REQ;
      if (req[i] && (d < best_d)) begin
        best_d = d;
        found  = 1'b1;
        index  = GRANT_W'(i);
      end
    end
  end

endmodule

// File: rtl/aqp_esp_tx_arb.sv
// rtl/aqp_esp_tx_arb.sv - packet-atomic round-robin arbiter for the ESP TX FIFO; optional AQP_ESP_TX_ARB_TIMEOUT_EN
module aqp_esp_tx_arb
  import aqp_esp_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [ESP_ENTRY_W-1:0] fifo_wrdata,
  output logic                   fifo_wr_en,
  input  logic                   fifo_full,
  output logic                   busy,
  output logic [GRANT_W-1:0]     grant_id,
  output logic [15:0]            pkt_count,
  output logic                   err_timeout,
  input  logic                   err_clr
);

  logic [0:0]         state;
  logic [GRANT_W-1:0] rr_ptr;
  logic               sof;
  logic               pick_found;
  logic [GRANT_W-1:0] pick_idx;
  logic               g_valid;
  logic               g_last;
  logic [7:0]         g_data;
  logic               xfer;
  logic               accept;
  logic               done;
  logic               abort;

  aqp_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GRANT_W'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[8*i +: 8];
      end
    end
  end

  assign xfer   = (state == ST_XFER);
  assign accept = xfer && g_valid && !fifo_full;
  assign done   = accept && g_last;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = xfer && !fifo_full && (grant_id == GRANT_W'(i));
    end
  end

  assign fifo_wr_en  = accept;
  assign fifo_wrdata = esp_entry(sof, g_data);
  assign busy        = xfer;

`ifdef AQP_ESP_TX_ARB_TIMEOUT_EN
  logic [10:0] idle_cnt;

  // Only a silent grantee counts toward the abort; a full FIFO just holds the count.
  assign abort = xfer && !g_valid && (idle_cnt == 11'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (!xfer || accept) begin
        idle_cnt <= '0;
      end else if (!g_valid) begin
        idle_cnt <= idle_cnt + 11'd1;
      end
      if (abort) begin
        err_timeout <= 1'b1;
      end else if (err_clr) begin
        err_timeout <= 1'b0;
      end
    end
  end
`else
  logic unused_cfg;

  assign abort       = 1'b0;
  assign err_timeout = 1'b0;
  assign unused_cfg  = ^{err_clr, 32'(TIMEOUT)};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= GRANT_W'(NUM_REQ - 1);
      sof       <= 1'b0;
      grant_id  <= '0;
      pkt_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            sof      <= 1'b1;
            state    <= ST_XFER;
          end
        end
        default: begin
          if (accept) begin
            sof <= 1'b0;
          end
          if (done) begin
            rr_ptr    <= grant_id;
            pkt_count <= pkt_count + 16'd1;
            state     <= ST_IDLE;
          end else if (abort) begin
            rr_ptr <= grant_id;
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aqp_esp_tx_arb.sv
// tb/tb_aqp_esp_tx_arb.sv - directed bench for aqp_esp_tx_arb; timeout steps under AQP_ESP_TX_ARB_TIMEOUT_EN
module tb_aqp_esp_tx_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] req_data;
  logic [2:0]  req_valid;
  logic [2:0]  req_last;
  logic [2:0]  req_ready;
  logic [8:0]  fifo_wrdata;
  logic        fifo_wr_en;
  logic        fifo_full;
  logic        busy;
  logic [2:0]  grant_id;
  logic [15:0] pkt_count;
  logic        err_timeout;
  logic        err_clr;

  typedef struct {
    int         rid;
    logic       last;
    logic [7:0] d;
  } ent_t;

  typedef struct {
    int         cyc;
    logic [2:0] gid;
    logic [8:0] d;
  } wr_t;

  ent_t rq[$];
  wr_t  wlog[$];
  int   cyc = 0;
  int   busy_cnt = 0;
  int   total = 0;
  int   bad = 0;
  int   base;
  int   b0;
  int   pexp;

  aqp_esp_tx_arb #(.NUM_REQ(3), .TIMEOUT(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_data    (req_data),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .fifo_wrdata (fifo_wrdata),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_full   (fifo_full),
    .busy        (busy),
    .grant_id    (grant_id),
    .pkt_count   (pkt_count),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  // requester model: each port presents the oldest queued byte addressed to it
  initial begin
    logic [2:0]  acc;
    logic [2:0]  v;
    logic [2:0]  l;
    logic [23:0] dd;
    bit          f;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (acc[i]) begin
          for (int j = 0; j < rq.size(); j++) begin
            if (rq[j].rid == i) begin
              rq.delete(j);
              break;
            end
          end
        end
      end
      v  = '0;
      l  = '0;
      dd = '0;
      for (int i = 0; i < 3; i++) begin
        f = 1'b0;
        for (int j = 0; j < rq.size(); j++) begin
          if (!f && rq[j].rid == i) begin
            v[i]         = 1'b1;
            l[i]         = rq[j].last;
            dd[8*i +: 8] = rq[j].d;
            f            = 1'b1;
          end
        end
      end
      req_valid = v;
      req_last  = l;
      req_data  = dd;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (busy === 1'b1) busy_cnt = busy_cnt + 1;
      if (fifo_wr_en === 1'b1) wlog.push_back('{cyc, grant_id, fifo_wrdata});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input int rid, input logic [7:0] d, input logic last);
    rq.push_back('{rid, last, d});
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wr_at(input int k);
    if (k < wlog.size()) return {20'd0, wlog[k].gid, wlog[k].d};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int wcyc(input int k);
    if (k < wlog.size()) return wlog[k].cyc;
    return -1000;
  endfunction

  task automatic check_wr(input string tag, input int k, input logic [2:0] gid, input logic [8:0] d);
    check(tag, wr_at(k), {20'd0, gid, d});
  endtask

  initial begin
    reset_n   = 1'b0;
    fifo_full = 1'b0;
    err_clr   = 1'b0;
    run(2);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_err", err_timeout, 0);
    check("rst_ready", req_ready, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    reset_n = 1'b1;
    tick();

    // all three requesters contending: 0,1,2,0 with one idle cycle between frames
    base = wlog.size();
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1); push(0, 8'h12, 1'b0); push(0, 8'h13, 1'b1);
    push(1, 8'h20, 1'b0); push(1, 8'h21, 1'b1);
    push(2, 8'h30, 1'b0); push(2, 8'h31, 1'b1);
    run(16);
    check("rr_pkt", pkt_count, 4);
    check("rr_busy_end", busy, 0);
    check_wr("rr_w0", base + 0, 3'd0, 9'h110);
    check_wr("rr_w1", base + 1, 3'd0, 9'h011);
    check_wr("rr_w2", base + 2, 3'd1, 9'h120);
    check_wr("rr_w3", base + 3, 3'd1, 9'h021);
    check_wr("rr_w4", base + 4, 3'd2, 9'h130);
    check_wr("rr_w5", base + 5, 3'd2, 9'h031);
    check_wr("rr_w6", base + 6, 3'd0, 9'h112);
    check_wr("rr_w7", base + 7, 3'd0, 9'h013);
    check("rr_beat", wcyc(base + 1) - wcyc(base), 1);
    check("rr_gap_a", wcyc(base + 2) - wcyc(base + 1), 2);
    check("rr_gap_b", wcyc(base + 6) - wcyc(base + 5), 2);

    // single requester, 3-byte frame on req1
    base = wlog.size();
    b0   = busy_cnt;
    push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b0); push(1, 8'h43, 1'b1);
    tick(); #1;
    check("p1_arb_ready", req_ready, 0);
    check("p1_arb_busy", busy, 0);
    tick(); #1;
    check("p1_busy", busy, 1);
    check("p1_grant", grant_id, 1);
    check("p1_ready", req_ready, 3'b010);
    check("p1_wr_en", fifo_wr_en, 1);
    check("p1_wrdata", fifo_wrdata, 9'h141);
    run(6);
    check("p1_busy_cycles", busy_cnt - b0, 3);
    check("p1_pkt", pkt_count, 5);
    check("p1_count", wlog.size() - base, 3);
    check_wr("p1_w0", base + 0, 3'd1, 9'h141);
    check_wr("p1_w1", base + 1, 3'd1, 9'h042);
    check_wr("p1_w2", base + 2, 3'd1, 9'h043);

    // FIFO full for 4 cycles while req0 sits on byte 2 of 4
    base = wlog.size();
    push(0, 8'h60, 1'b0); push(0, 8'h61, 1'b0); push(0, 8'h62, 1'b0); push(0, 8'h63, 1'b1);
    tick();
    tick(); #1;
    check("ff_first", fifo_wrdata, 9'h160);
    tick();
    fifo_full = 1'b1;
    #1;
    check("ff_wr_en", fifo_wr_en, 0);
    check("ff_ready", req_ready, 0);
    check("ff_busy", busy, 1);
    check("ff_grant", grant_id, 0);
    repeat (3) begin
      tick(); #1;
      check("ff_hold_wr_en", fifo_wr_en, 0);
      check("ff_hold_busy", busy, 1);
    end
    tick();
    fifo_full = 1'b0;
    #1;
    check("ff_resume_wr_en", fifo_wr_en, 1);
    check("ff_resume_data", fifo_wrdata, 9'h061);
    check("ff_resume_ready", req_ready, 3'b001);
    run(6);
    check("ff_count", wlog.size() - base, 4);
    check_wr("ff_w0", base + 0, 3'd0, 9'h160);
    check_wr("ff_w1", base + 1, 3'd0, 9'h061);
    check_wr("ff_w2", base + 2, 3'd0, 9'h062);
    check_wr("ff_w3", base + 3, 3'd0, 9'h063);
    check("ff_pkt", pkt_count, 6);
    check("ff_err", err_timeout, 0);

    // single-byte frame carries sof and last together
    base = wlog.size();
    push(0, 8'h55, 1'b1);
    run(4);
    check_wr("sb_w0", base, 3'd0, 9'h155);
    check("sb_pkt", pkt_count, 7);

    // reset in the middle of a 5-byte frame on req2
    push(2, 8'h70, 1'b0); push(2, 8'h71, 1'b0); push(2, 8'h72, 1'b0);
    push(2, 8'h73, 1'b0); push(2, 8'h74, 1'b1);
    run(3);
    check("mr_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_grant", grant_id, 0);
    check("mr_pkt", pkt_count, 0);
    check("mr_err", err_timeout, 0);
    check("mr_ready", req_ready, 0);
    check("mr_wr_en", fifo_wr_en, 0);
    rq.delete();
    tick();
    reset_n = 1'b1;
    tick();
    base = wlog.size();
    push(1, 8'h5C, 1'b1);
    push(0, 8'h5B, 1'b1);
    run(6);
    check_wr("mr_next0", base + 0, 3'd0, 9'h15B);
    check_wr("mr_next1", base + 1, 3'd1, 9'h15C);
    check("mr_pkt_after", pkt_count, 2);
    pexp = 2;

`ifdef AQP_ESP_TX_ARB_TIMEOUT_EN
    // req2 goes silent after one byte; waiting req0 must get the FIFO
    base = wlog.size();
    push(2, 8'h80, 1'b0);
    push(0, 8'h81, 1'b1);
    run(10); #1;
    check("to_busy_pre", busy, 1);
    check("to_err_pre", err_timeout, 0);
    check("to_grant_pre", grant_id, 2);
    tick(); #1;
    check("to_err", err_timeout, 1);
    check("to_busy", busy, 0);
    run(4);
    check_wr("to_w0", base + 0, 3'd2, 9'h180);
    check_wr("to_w1", base + 1, 3'd0, 9'h181);
    check("to_pkt", pkt_count, 3);
    pexp = 3;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    check("to_clr", err_timeout, 0);
`else
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    check("noto_err", err_timeout, 0);
`endif
    check("pre_wrap_pkt", pkt_count, pexp);

    // packet counter wrap
    force dut.pkt_count = 16'hFFFE;
    #1;
    release dut.pkt_count;
    base = wlog.size();
    push(1, 8'h90, 1'b1);
    run(4);
    check("wrap_ffff", pkt_count, 16'hFFFF);
    push(2, 8'h91, 1'b1);
    run(4);
    check("wrap_zero", pkt_count, 16'h0000);
    check_wr("wrap_w0", base + 0, 3'd1, 9'h190);
    check_wr("wrap_w1", base + 1, 3'd2, 9'h191);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
